part3_mac_pipe: RTL and testbench
=================================

Name: part3_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the successor to the fixed 8x8/16-bit MAC. It adds generic operand and accumulator widths, a configurable multiplier pipeline depth, a per-sample accumulator clear, and overflow reporting. It streams one operand pair per cycle, qualified by valid_in, into a single running accumulator, and sits on the datapath between operand producers and result consumers.

Parameters:
WIDTH, 8, signed operand width of a and b (>= 2).
ACC_WIDTH, 16, accumulator/output width; must satisfy ACC_WIDTH >= 2*WIDTH (checked by an elaboration-time assertion).
PIPE_STAGES, 0, number of register stages after the multiplier (0..4).

Ports:
clk  input  1  single clock, rising-edge.
reset  input  1  synchronous, active-high reset.
a  input  WIDTH  signed operand A.
b  input  WIDTH  signed operand B.
valid_in  input  1  a, b and clear_acc are valid this cycle.
clear_acc  input  1  when sampled with valid_in: this sample restarts the accumulation.
f  output  ACC_WIDTH  signed accumulator value.
valid_out  output  1  f was updated this cycle.
overflow  output  1  the update in this cycle overflowed ACC_WIDTH.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, applied on the rising edge of clk when reset=1.
- Reset values: f=0, valid_out=0, overflow=0. All internal operand, product and valid/clear pipeline registers are cleared.
- Stage 0 (input): on an edge with valid_in=1, register a, b and clear_acc, and set valid bit v0=1. With valid_in=0, v0=0 and the data registers hold their values.
- Multiply: p = a_reg * b_reg, signed, full 2*WIDTH bits. It is followed by PIPE_STAGES registers. Each stage carries p, its valid bit and its clear bit in lockstep; there are no stalls.
- Accumulate: on an edge where the final-stage valid bit is 1:
  - clear=1: f <= sext(p).
  - clear=0: f <= f + sext(p), computed in ACC_WIDTH+1 bits.
  - In both cases valid_out <= 1.
- If the final-stage valid bit is 0: f holds, valid_out <= 0, overflow <= 0.
- Latency: a sample taken at edge N appears on f, with valid_out=1, after edge N+1+PIPE_STAGES. Throughput is 1 sample per cycle.
- valid_out and overflow are one-cycle pulses aligned with the f update. They are not sticky.
- Overflow: true when the signed ACC_WIDTH+1 sum falls outside the ACC_WIDTH range. A clear=1 update never overflows, given the ACC_WIDTH >= 2*WIDTH constraint.
- Default arithmetic wraps two's-complement modulo 2^ACC_WIDTH.
- Bubbles between samples are allowed. The accumulation continues across any number of idle cycles.
- Reset mid-operation: all in-flight samples are discarded. No valid_out is produced for them, and f=0 on the next cycle.
- valid_in together with reset: reset wins and the sample is dropped.
- Corner product: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), which must be representable. With WIDTH=8 this is -128*-128 = 16384.

Optional Feature:
Macro PART3_MAC_SATURATE_EN.
- Defined: on overflow, f is clamped to the maximum positive value (2^(ACC_WIDTH-1)-1) or the minimum negative value (-2^(ACC_WIDTH-1)), matching the sign of the true sum. overflow=1 still pulses.
- Undefined: f wraps as described above, and overflow=1 pulses on the wrapping update.
- The port list is identical in both builds.

Test Plan:
(WIDTH=8, ACC_WIDTH=16, PIPE_STAGES=2 unless noted.)
1. Reset, then one sample a=3, b=4, clear_acc=1 at edge N -> valid_out=1 only after edge N+3, f=12, overflow=0. f is 0 and valid_out is 0 before that.
2. Back-to-back samples (3,4,clr=1), (-2,5), (127,127) on consecutive edges -> f=12, 2, 16131 on three consecutive cycles, with valid_out high for exactly 3 cycles.
3. Idle gaps: samples (10,10,clr=1) and (-5,2) separated by 4 idle cycles -> f=100 holds through the gap with valid_out=0, then f=90.
4. Clear mid-stream: with f=16131, send (-1,-1,clr=1) followed by (-128,-128) -> f=1, then f=16385.
5. Overflow: (127,127,clr=1) followed by two more (127,127) -> f=16129, 32258, then the third update gives overflow=1 and:
   - f=-17149 without the macro (wrap).
   - f=32767 with PART3_MAC_SATURATE_EN.
   - Repeat with PIPE_STAGES=0: latency becomes 1 edge.
6. Reset mid-pipeline: a sample at edge N, then reset=1 at edge N+1 with valid_in=1 -> no valid_out ever appears for either sample, and f=0 from edge N+1 onward.

Source files
------------

// File: rtl/part3_mac_pipe.sv
// Pipelined signed multiply-accumulate with per-sample clear and overflow reporting.
// Define PART3_MAC_SATURATE_EN to clamp f on overflow instead of wrapping.
module part3_mac_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned PIPE_STAGES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    input  logic                        valid_in,
    input  logic                        clear_acc,
    output logic signed [ACC_WIDTH-1:0] f,
    output logic                        valid_out,
    output logic                        overflow
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] MaxVal = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MinVal = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (WIDTH < 2) begin : g_bad_width
        $error("part3_mac_pipe: WIDTH must be at least 2");
    end
    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc
        $error("part3_mac_pipe: ACC_WIDTH must be at least 2*WIDTH");
    end
    if (PIPE_STAGES > 4) begin : g_bad_pipe
        $error("part3_mac_pipe: PIPE_STAGES must be in 0..4");
    end

    // Input stage
    logic signed [WIDTH-1:0] a_q, b_q;
    logic                    clr0_q, v0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            clr0_q <= 1'b0;
            v0_q   <= 1'b0;
        end else begin
            v0_q <= valid_in;
            if (valid_in) begin
                a_q    <= a;
                b_q    <= b;
                clr0_q <= clear_acc;
            end
        end
    end

    logic signed [PW-1:0] prod;
    assign prod = PW'(a_q) * PW'(b_q);

    // Final-stage product, valid and clear after the optional register chain
    logic signed [PW-1:0] fin_p;
    logic                 fin_v, fin_c;

    if (PIPE_STAGES == 0) begin : g_no_pipe
        assign fin_p = prod;
        assign fin_v = v0_q;
        assign fin_c = clr0_q;
    end else begin : g_pipe
        logic signed [PW-1:0]   p_q [PIPE_STAGES];
        logic [PIPE_STAGES-1:0] v_q, c_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                    p_q[i] <= '0;
                end
                v_q <= '0;
                c_q <= '0;
            end else begin
                p_q[0] <= prod;
                v_q[0] <= v0_q;
                c_q[0] <= clr0_q;
                for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                    p_q[i] <= p_q[i-1];
                    v_q[i] <= v_q[i-1];
                    c_q[i] <= c_q[i-1];
                end
            end
        end

        assign fin_p = p_q[PIPE_STAGES-1];
        assign fin_v = v_q[PIPE_STAGES-1];
        assign fin_c = c_q[PIPE_STAGES-1];
    end

    // Accumulator
    logic signed [ACC_WIDTH-1:0] f_q, f_d;
    logic                        vout_q, ovf_q, ovf_d;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        sum_ovf;

    assign p_ext   = ACC_WIDTH'(fin_p);
    assign sum     = (ACC_WIDTH+1)'(f_q) + (ACC_WIDTH+1)'(p_ext);
    // Top two bits disagree when the true sum does not fit in ACC_WIDTH
    assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        f_d   = f_q;
        ovf_d = 1'b0;
        if (fin_v) begin
            if (fin_c) begin
                f_d = p_ext;
            end else begin
                ovf_d = sum_ovf;
                f_d   = sum[ACC_WIDTH-1:0];
`ifdef PART3_MAC_SATURATE_EN
                if (sum_ovf) begin
                    f_d = sum[ACC_WIDTH] ? MinVal : MaxVal;
                end
`else
                if (sum_ovf && 1'b0) begin
                    f_d = sum[ACC_WIDTH] ? MinVal : MaxVal;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q    <= '0;
            vout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            f_q    <= f_d;
            vout_q <= fin_v;
            ovf_q  <= ovf_d;
        end
    end

    assign f         = f_q;
    assign valid_out = vout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_part3_mac_pipe.sv
// Randomised and directed bench for part3_mac_pipe, PIPE_STAGES=2 and PIPE_STAGES=0 side by side,
// checked against a queue-based accumulate model.
module tb_part3_mac_pipe;

    localparam int AW = 16;
    localparam longint MaxV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MinV = -(longint'(1) << (AW - 1));
    localparam longint Span = longint'(1) << AW;

    logic clk = 1'b0;
    logic reset, valid_in, clear_acc;
    logic signed [7:0] a, b;
    logic signed [AW-1:0] f2, f0;
    logic vo2, vo0, ov2, ov0;

    always #5 clk = ~clk;

    part3_mac_pipe #(.WIDTH(8), .ACC_WIDTH(AW), .PIPE_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f2), .valid_out(vo2), .overflow(ov2)
    );

    part3_mac_pipe #(.WIDTH(8), .ACC_WIDTH(AW), .PIPE_STAGES(0)) dut0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f0), .valid_out(vo0), .overflow(ov0)
    );

    // Every accepted sample with the edge it was taken on; each model walks it with its own pointer
    int     hist_a[$], hist_b[$], hist_e[$];
    bit     hist_c[$];
    int     ptr[2];
    longint macc[2];
    bit     mv[2], mo[2];
    int     ps[2];
    int     edge_n;
    int     n_vec, n_err;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0;
            mo[k] = 1'b0;
            if (reset) begin
                ptr[k]  = hist_a.size();
                macc[k] = 0;
            end else if (ptr[k] < hist_a.size() && hist_e[ptr[k]] + 1 + ps[k] == edge_n) begin
                longint prod, sum;
                prod = longint'(hist_a[ptr[k]] * hist_b[ptr[k]]);
                if (hist_c[ptr[k]]) begin
                    sum = prod;
                end else begin
                    sum = macc[k] + prod;
                    if (sum > MaxV) begin
                        mo[k] = 1'b1;
`ifdef PART3_MAC_SATURATE_EN
                        sum = MaxV;
`else
                        sum = sum - Span;
`endif
                    end else if (sum < MinV) begin
                        mo[k] = 1'b1;
`ifdef PART3_MAC_SATURATE_EN
                        sum = MinV;
`else
                        sum = sum + Span;
`endif
                    end
                end
                macc[k] = sum;
                mv[k]   = 1'b1;
                ptr[k]++;
            end
        end
        if (!reset && valid_in) begin
            hist_a.push_back(int'(a));
            hist_b.push_back(int'(b));
            hist_c.push_back(clear_acc);
            hist_e.push_back(edge_n);
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input bit clr, input int av, input int bv);
        reset     = rst;
        valid_in  = v;
        clear_acc = clr;
        a         = 8'(av);
        b         = 8'(bv);
        @(posedge clk);
        model_edge();
        #1;
        check("f_ps2", f2, macc[0]);
        check("valid_out_ps2", vo2, mv[0]);
        check("overflow_ps2", ov2, mo[0]);
        check("f_ps0", f0, macc[1]);
        check("valid_out_ps0", vo0, mv[1]);
        check("overflow_ps0", ov0, mo[1]);
        @(negedge clk);
    endtask

    // Idle cycles still wiggle the data inputs to show they are ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128);
        end
    endtask

    function automatic int pick_operand();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return 127;
        if (r == 1) return -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        ps[0] = 2;
        ps[1] = 0;
        n_vec = 0;
        n_err = 0;
        edge_n = 0;
        reset = 1'b1;
        valid_in = 1'b0;
        clear_acc = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 1'b1, 5, 5);

        // Single sample, latency
        cycle(1'b0, 1'b1, 1'b1, 3, 4);
        idle(4);
        check("t1_final_f", f2, 12);

        // Back-to-back
        cycle(1'b0, 1'b1, 1'b1, 3, 4);
        cycle(1'b0, 1'b1, 1'b0, -2, 5);
        cycle(1'b0, 1'b1, 1'b0, 127, 127);
        idle(4);
        check("t2_final_f", f2, 16131);

        // Clear mid-stream, corner product
        cycle(1'b0, 1'b1, 1'b1, -1, -1);
        cycle(1'b0, 1'b1, 1'b0, -128, -128);
        idle(4);
        check("t4_final_f", f2, 16385);

        // Idle gap
        cycle(1'b0, 1'b1, 1'b1, 10, 10);
        idle(4);
        cycle(1'b0, 1'b1, 1'b0, -5, 2);
        idle(4);
        check("t3_final_f", f2, 90);

        // Overflow
        cycle(1'b0, 1'b1, 1'b1, 127, 127);
        cycle(1'b0, 1'b1, 1'b0, 127, 127);
        cycle(1'b0, 1'b1, 1'b0, 127, 127);
        idle(4);
`ifdef PART3_MAC_SATURATE_EN
        check("t5_final_f_ps2", f2, 32767);
        check("t5_final_f_ps0", f0, 32767);
`else
        check("t5_final_f_ps2", f2, -17149);
        check("t5_final_f_ps0", f0, -17149);
`endif

        // Reset mid-pipeline with a sample alongside
        cycle(1'b0, 1'b1, 1'b1, 9, 9);
        cycle(1'b1, 1'b1, 1'b0, 7, 7);
        idle(5);
        check("t6_final_f_ps2", f2, 0);
        check("t6_final_f_ps0", f0, 0);

        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, pick_operand(), pick_operand());
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
